// File: rtl/mux_pkg.sv
// Shared encodings and helpers for the round-robin arbitrating mux.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package mux_pkg;

    // Selection mode on the mode input; the reserved code behaves as address-select.
    typedef enum logic [1:0] {
        MODE_SEL  = 2'b00,
        MODE_PRIO = 2'b01,
        MODE_RR   = 2'b10,
        MODE_RSVD = 2'b11
    } mode_e;

    // Channel index width: at least one bit even for tiny channel counts.
    function automatic int ch_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arb_mux_if.sv
// Handshake bundle between N_CH producers, the arbitrating mux and one consumer.
// Latency: n/a (wires only).
// Backpressure: in_ready per channel, out_ready from the consumer.
//   mode/sel   : selection mode and address-select channel
//   in_*       : per-channel valid, packed data, combinational ready
//   out_*      : registered word, its source channel, valid/ready handshake
interface rr_arb_mux_if #(
    parameter int N_CH  = 4,
    parameter int WIDTH = 8
);
    localparam int CH_W = mux_pkg::ch_width(N_CH);

    logic [1:0]            mode;
    logic [CH_W-1:0]       sel;
    logic [N_CH-1:0]       in_valid;
    logic [N_CH*WIDTH-1:0] in_data;
    logic [N_CH-1:0]       in_ready;
    logic                  out_valid;
    logic                  out_ready;
    logic [WIDTH-1:0]      out_data;
    logic [CH_W-1:0]       out_ch;

    // Environment side: drives requests and control, consumes the output word.
    modport master (
        output mode, sel, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_ch
    );

    // Mux side.
    modport slave (
        input  mode, sel, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_ch
    );

endinterface

// File: rtl/rr_arb_mux_arb_pick.sv
// Combinational grant selection: address-select, fixed priority or round-robin.
// Latency: 0 cycles (pure combinational).
// Backpressure: none here; the caller qualifies the grant with its load condition.
//   req   : per-channel request      ptr  : round-robin search start
//   mode  : selection mode           sel  : address for address-select mode
//   grant : one-hot (or zero)        idx  : encoded grant    any : a grant exists
module arb_pick
    import mux_pkg::*;
#(
    parameter int N_CH = 4,
    parameter int CH_W = 2
) (
    input  logic [N_CH-1:0] req,
    input  logic [CH_W-1:0] ptr,
    input  mode_e           mode,
    input  logic [CH_W-1:0] sel,
    output logic [N_CH-1:0] grant,
    output logic [CH_W-1:0] idx,
    output logic            any
);

    int k;

    // Grant is a function of req/mode/sel/ptr only; data never participates.
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        k     = 0;
        case (mode)
            MODE_PRIO: begin
                for (int i = 0; i < N_CH; i++) begin
                    if (req[i] && !any) begin
                        grant[i] = 1'b1;
                        idx      = CH_W'(i);
                        any      = 1'b1;
                    end
                end
            end
            MODE_RR: begin
                // Search ptr, ptr+1, ... wrapping; first hit wins.
                for (int off = 0; off < N_CH; off++) begin
                    k = (int'(ptr) + off) % N_CH;
                    if (req[k] && !any) begin
                        grant[k] = 1'b1;
                        idx      = CH_W'(k);
                        any      = 1'b1;
                    end
                end
            end
            default: begin
                // Address-select (and reserved). An address beyond N_CH-1
                // matches no loop index, so it grants nothing.
                for (int i = 0; i < N_CH; i++) begin
                    if (int'(sel) == i && req[i]) begin
                        grant[i] = 1'b1;
                        idx      = CH_W'(i);
                        any      = 1'b1;
                    end
                end
            end
        endcase
    end

endmodule

// File: rtl/rr_arb_mux.sv
// N_CH-to-1 arbitrating mux with a single registered output word.
// Latency: 1 cycle from input transfer to out_valid/out_data/out_ch.
// Backpressure: full throughput; while the held word is stalled all in_ready are 0.
//   clk, rst_n : clock and async active-low reset
//   bus        : rr_arb_mux_if slave (mode, sel, in_*, out_*)
module rr_arb_mux
    import mux_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int WIDTH = 8
) (
    input logic        clk,
    input logic        rst_n,
    rr_arb_mux_if.slave bus
);

    localparam int CH_W = ch_width(N_CH);

    logic [N_CH-1:0]  grant;
    logic [CH_W-1:0]  pick_idx;
    logic             pick_any;
    logic [CH_W-1:0]  ptr;
    logic             load;
    logic             xfer;
    mode_e            mode_q;

    logic             out_valid_q;
    logic [WIDTH-1:0] out_data_q;
    logic [CH_W-1:0]  out_ch_q;

    assign mode_q = mode_e'(bus.mode);

    arb_pick #(
        .N_CH (N_CH),
        .CH_W (CH_W)
    ) u_pick (
        .req   (bus.in_valid),
        .ptr   (ptr),
        .mode  (mode_q),
        .sel   (bus.sel),
        .grant (grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    // The output register can take a word when empty or being drained this cycle.
    assign load = !out_valid_q || bus.out_ready;

    // rst_n gates ready: during reset the register reads empty, so load alone
    // would otherwise advertise readiness.
    assign bus.in_ready = (rst_n && load) ? grant : '0;
    assign xfer         = rst_n && load && pick_any;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            ptr         <= '0;
        end else begin
            if (load) begin
                out_valid_q <= xfer;
                if (xfer) begin
                    out_data_q <= bus.in_data[int'(pick_idx)*WIDTH +: WIDTH];
                    out_ch_q   <= pick_idx;
                end
            end
            if (xfer && mode_q == MODE_RR) begin
                ptr <= (pick_idx == CH_W'(N_CH - 1)) ? '0 : pick_idx + 1'b1;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_ch    = out_ch_q;

endmodule
